// File: rtl/nn_window_tiler.sv
// nn_window_tiler: pixel band buffer and WIN x WIN window replay
// for the nn classifier, with backpressure and overflow flag.
module nn_window_tiler #(
    parameter int LINE_W = 640,
    parameter int WIN    = 28,
    parameter int PIX_W  = 8,
    parameter int THRESH = 50
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic [PIX_W-1:0]              pix_in,
    input  logic                          pix_valid,
    input  logic                          sof,
    input  logic                          eof,
    output logic [PIX_W-1:0]              x_out,
    output logic                          x_valid,
    input  logic                          x_ready,
    output logic                          win_first,
    output logic                          win_last,
    output logic [$clog2(LINE_W/WIN)-1:0] win_col,
    output logic [7:0]                    win_row,
    output logic                          overflow
);

    localparam int N  = WIN * LINE_W;
    localparam int NW = LINE_W / WIN;
    localparam int AW = $clog2(N);
    localparam int KW = $clog2(WIN);
    localparam int CW = $clog2(NW);
    localparam int TW = 8 + CW + 2;
    localparam int EW = TW + PIX_W;

    localparam logic [AW-1:0]    LAST_A = AW'(N - 1);
    localparam logic [AW-1:0]    LW_A   = AW'(LINE_W);
    localparam logic [AW-1:0]    WIN_A  = AW'(WIN);
    localparam logic [KW-1:0]    K_MAX  = KW'(WIN - 1);
    localparam logic [CW-1:0]    W_MAX  = CW'(NW - 1);
    localparam logic [PIX_W-1:0] TH     = PIX_W'(THRESH);
    localparam logic [PIX_W-1:0] SAT    = {1'b0, {(PIX_W-1){1'b1}}};

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;
    typedef enum logic {R_IDLE, R_RUN} rstate_t;

    logic [PIX_W-1:0] mem0 [N];
    logic [PIX_W-1:0] mem1 [N];
    logic [PIX_W-1:0] rdata_q;

    wstate_t          wst_q, wst_d;
    logic [AW-1:0]    wa_q, wa_d, waddr;
    logic             wbank_q, wbank_d, wsel, we;
    logic             rbank_q, rbank_d;
    logic [7:0]       band_q, band_d, rband_q, rband_d;
    logic             ovf_q, ovf_d;
    logic             rgo, rd_free, rel;

    rstate_t          rs_q, rs_d;
    logic [KW-1:0]    c_q, c_d, r_q, r_d;
    logic [CW-1:0]    w_q, w_d;
    logic             done_q, done_d;
    logic             issue;
    logic [AW-1:0]    ra;
    logic [TW-1:0]    tag;
    logic             rd_vld_q;
    logic [TW-1:0]    rd_tag_q;

    logic [EW-1:0]    e0_q, e0_d, e1_q, e1_d;
    logic [1:0]       cnt_q, cnt_d, cp;
    logic [2:0]       occ;
    logic             pop;

    logic [PIX_W-1:0] half, samp;

    // Contrast boost: halve, then saturate anything above threshold
    always_comb begin
        half = pix_in >> 1;
        samp = (half > TH) ? SAT : half;
    end

    // Output-side handshake and bank release on the final accepted beat
    always_comb begin
        pop     = (cnt_q != 2'd0) && x_ready;
        rel     = (rs_q == R_RUN) && pop && e0_q[PIX_W+1]
                  && (e0_q[PIX_W+2 +: CW] == W_MAX);
        rd_free = (rs_q == R_IDLE) || rel;
    end

    // Write FSM: fill bank, hand over on full band, or drop one band
    always_comb begin
        wst_d   = wst_q;
        wa_d    = wa_q;
        wbank_d = wbank_q;
        rbank_d = rbank_q;
        band_d  = band_q;
        rband_d = rband_q;
        ovf_d   = ovf_q;
        we      = 1'b0;
        rgo     = 1'b0;
        wsel    = wbank_q;
        waddr   = wa_q;
        if (sof) begin
            wst_d  = W_FILL;
            wa_d   = '0;
            band_d = '0;
            ovf_d  = 1'b0;
            // Never refill the bank a still-running replay is reading
            wbank_d = (rs_q == R_RUN) ? ~rbank_q : 1'b0;
            wsel    = wbank_d;
            waddr   = '0;
            if (pix_valid) begin
                we   = 1'b1;
                wa_d = AW'(1);
            end
        end else if (eof) begin
            wst_d = W_IDLE;
        end else if (pix_valid) begin
            case (wst_q)
                W_FILL: begin
                    we = 1'b1;
                    if (wa_q == LAST_A) begin
                        wa_d   = '0;
                        band_d = band_q + 8'd1;
                        if (rd_free) begin
                            rgo     = 1'b1;
                            rbank_d = wbank_q;
                            wbank_d = ~wbank_q;
                            rband_d = band_q;
                        end else begin
                            wst_d = W_DROP;
                            ovf_d = 1'b1;
                        end
                    end else begin
                        wa_d = wa_q + AW'(1);
                    end
                end
                W_DROP: begin
                    if (wa_q == LAST_A) begin
                        wa_d   = '0;
                        band_d = band_q + 8'd1;
                        wst_d  = W_FILL;
                    end else begin
                        wa_d = wa_q + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Read FSM: walk c, then r, then w while pipeline slots are free
    always_comb begin
        rs_d   = rs_q;
        c_d    = c_q;
        r_d    = r_q;
        w_d    = w_q;
        done_d = done_q;
        occ    = 3'(cnt_q) + 3'(rd_vld_q) - 3'(pop);
        issue  = (rs_q == R_RUN) && !done_q && (occ <= 3'd1);
        ra     = AW'(r_q) * LW_A + AW'(w_q) * WIN_A + AW'(c_q);
        tag    = {rband_q, w_q,
                  (c_q == K_MAX) && (r_q == K_MAX),
                  (c_q == '0) && (r_q == '0)};
        if (issue) begin
            if (c_q == K_MAX) begin
                c_d = '0;
                if (r_q == K_MAX) begin
                    r_d = '0;
                    if (w_q == W_MAX) done_d = 1'b1;
                    else w_d = w_q + CW'(1);
                end else begin
                    r_d = r_q + KW'(1);
                end
            end else begin
                c_d = c_q + KW'(1);
            end
        end
        if (rel) rs_d = R_IDLE;
        if (rgo) begin
            rs_d   = R_RUN;
            c_d    = '0;
            r_d    = '0;
            w_d    = '0;
            done_d = 1'b0;
        end
    end

    // Two-entry skid buffer fed by the registered RAM read
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cp    = cnt_q - {1'b0, pop};
        if (pop) e0_d = e1_q;
        if (rd_vld_q) begin
            if (cp == 2'd0) e0_d = {rd_tag_q, rdata_q};
            else e1_d = {rd_tag_q, rdata_q};
        end
        cnt_d = cp + {1'b0, rd_vld_q};
    end

    // Band storage with registered read
    always_ff @(posedge Clk) begin
        if (we && wsel) mem1[waddr] <= samp;
        if (we && !wsel) mem0[waddr] <= samp;
        if (issue) rdata_q <= rbank_q ? mem1[ra] : mem0[ra];
    end

    // State registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wst_q    <= W_IDLE;
            wa_q     <= '0;
            wbank_q  <= 1'b0;
            rbank_q  <= 1'b0;
            band_q   <= '0;
            rband_q  <= '0;
            ovf_q    <= 1'b0;
            rs_q     <= R_IDLE;
            c_q      <= '0;
            r_q      <= '0;
            w_q      <= '0;
            done_q   <= 1'b0;
            rd_vld_q <= 1'b0;
            rd_tag_q <= '0;
            e0_q     <= '0;
            e1_q     <= '0;
            cnt_q    <= '0;
        end else begin
            wst_q    <= wst_d;
            wa_q     <= wa_d;
            wbank_q  <= wbank_d;
            rbank_q  <= rbank_d;
            band_q   <= band_d;
            rband_q  <= rband_d;
            ovf_q    <= ovf_d;
            rs_q     <= rs_d;
            c_q      <= c_d;
            r_q      <= r_d;
            w_q      <= w_d;
            done_q   <= done_d;
            rd_vld_q <= issue;
            rd_tag_q <= tag;
            e0_q     <= e0_d;
            e1_q     <= e1_d;
            cnt_q    <= cnt_d;
        end
    end

    assign x_valid   = (cnt_q != 2'd0);
    assign x_out     = e0_q[PIX_W-1:0];
    assign win_first = x_valid & e0_q[PIX_W];
    assign win_last  = x_valid & e0_q[PIX_W+1];
    assign win_col   = e0_q[PIX_W+2 +: CW];
    assign win_row   = e0_q[PIX_W+2+CW +: 8];
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_nn_window_tiler.sv
// tb_nn_window_tiler: scoreboard bench for nn_window_tiler
// with LINE_W=8, WIN=4 (32-pixel bands, two windows each).
module tb_nn_window_tiler;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [7:0] pix_in;
    logic       pix_valid, sof, eof;
    logic [7:0] x_out;
    logic       x_valid, x_ready;
    logic       win_first, win_last;
    logic [0:0] win_col;
    logic [7:0] win_row;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;
    bit mon_en = 1'b0;
    logic [18:0] sbq [$];

    nn_window_tiler #(.LINE_W(8), .WIN(4), .PIX_W(8), .THRESH(50)) dut (
        .Clk(Clk), .Rst(Rst), .pix_in(pix_in), .pix_valid(pix_valid),
        .sof(sof), .eof(eof), .x_out(x_out), .x_valid(x_valid),
        .x_ready(x_ready), .win_first(win_first), .win_last(win_last),
        .win_col(win_col), .win_row(win_row), .overflow(overflow)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] conv(input logic [7:0] p);
        logic [7:0] h;
        h = p >> 1;
        return (h > 8'd50) ? 8'd127 : h;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // drive one full band; queue its window-order beats if expected
    task automatic send_band(input int base, input logic [7:0] row,
                             input bit exp, input bit with_sof);
        logic [7:0] s [32];
        for (int i = 0; i < 32; i++) begin
            pix_in    = 8'((base + i) & 255);
            pix_valid = 1'b1;
            sof       = with_sof && (i == 0);
            s[i]      = conv(pix_in);
            tick();
        end
        pix_valid = 1'b0;
        sof       = 1'b0;
        if (exp)
            for (int w = 0; w < 2; w++)
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        sbq.push_back({row, 1'(w),
                                       (r == 3) && (c == 3),
                                       (r == 0) && (c == 0),
                                       s[r*8 + w*4 + c]});
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && sbq.size() != 0; i++) tick();
        check(tag, sbq.size(), 0);
        idle(3);
    endtask

    // Ready pattern generator
    initial begin
        x_ready = 1'b1;
        forever begin
            @(posedge Clk);
            #1;
            if (rdy_mode == 0) x_ready = 1'b1;
            else if (rdy_mode == 1) x_ready = 1'b0;
            else x_ready = 1'($urandom_range(0, 1));
        end
    end

    // Scoreboard monitor: every valid beat must match the queue head
    always @(negedge Clk) begin
        if (mon_en && !Rst && x_valid) begin
            check("beat_avail", 32'(sbq.size() != 0), 1);
            if (sbq.size() != 0) begin
                check("beat", {win_row, win_col, win_last, win_first, x_out},
                      32'(sbq[0]));
                if (x_ready) void'(sbq.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        Rst = 1'b1; pix_in = '0; pix_valid = 1'b0; sof = 1'b0; eof = 1'b0;
        idle(3);
        check("rst_xv", x_valid, 0);
        check("rst_xo", x_out, 0);
        check("rst_wf", win_first, 0);
        check("rst_wl", win_last, 0);
        check("rst_wc", win_col, 0);
        check("rst_wr", win_row, 0);
        check("rst_ovf", overflow, 0);
        Rst = 1'b0;
        mon_en = 1'b1;
        idle(2);

        // ramp bands, always ready; second band covers 100 -> 50, 102 -> 127
        send_band(0, 8'd0, 1, 1);
        drain("drain_b0");
        send_band(90, 8'd1, 1, 0);
        drain("drain_b1");

        // random backpressure
        rdy_mode = 2;
        send_band(130, 8'd2, 1, 0);
        drain("drain_rand");
        rdy_mode = 0;
        idle(2);

        // overflow: replay stalled, second band overflows, third dropped
        rdy_mode = 1;
        idle(1);
        send_band(10, 8'd0, 1, 1);
        idle(5);
        send_band(40, 8'd1, 0, 0);
        check("ovf_set", overflow, 1);
        send_band(70, 8'd2, 0, 0);
        rdy_mode = 0;
        drain("drain_ovf_a");
        send_band(200, 8'd3, 1, 0);
        drain("drain_ovf_d");
        check("ovf_sticky", overflow, 1);

        // eof mid-band discards the partial band
        sof = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pix_in = 8'(i + 5); pix_valid = 1'b1;
            tick();
            sof = 1'b0;
        end
        pix_valid = 1'b0;
        eof = 1'b1;
        tick();
        eof = 1'b0;
        idle(40);
        check("eof_novalid", x_valid, 0);
        check("eof_ovf_clr", overflow, 0);
        send_band(60, 8'd0, 1, 1);
        drain("drain_eof");

        // Rst mid-replay
        send_band(20, 8'd0, 1, 1);
        idle(6);
        mon_en = 1'b0;
        Rst = 1'b1;
        tick();
        check("mrst_xv", x_valid, 0);
        check("mrst_xo", x_out, 0);
        check("mrst_wf", win_first, 0);
        check("mrst_wl", win_last, 0);
        check("mrst_wc", win_col, 0);
        check("mrst_wr", win_row, 0);
        check("mrst_ovf", overflow, 0);
        Rst = 1'b0;
        sbq.delete();
        tick();
        mon_en = 1'b1;
        send_band(150, 8'd0, 1, 1);
        drain("drain_rst");

        // sof during replay: replay completes, overflow clears
        rdy_mode = 1;
        idle(1);
        send_band(100, 8'd0, 1, 1);
        idle(5);
        send_band(33, 8'd1, 0, 0);
        check("ovf_set2", overflow, 1);
        rdy_mode = 0;
        idle(5);
        sof = 1'b1;
        tick();
        sof = 1'b0;
        tick();
        check("sof_ovf_clr", overflow, 0);
        drain("drain_sof");
        send_band(180, 8'd0, 1, 0);
        drain("drain_after_sof");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nn_window_tiler.md
# nn_window_tiler

Parametrised band-buffer and window tiler between the video pixel stream and the `nn` classifier. It converts incoming pixels to signed contrast-boosted samples and stores WIN lines per band in ping-pong banks. Each complete band is replayed as LINE_W/WIN square WIN×WIN windows, row-major, over a valid/ready stream. It adds backpressure, band-overflow detection and window-position tagging for the downstream digit overlay.

## Interface
- `LINE_W`, 640: active pixels per line; must be a multiple of `WIN`.
- `WIN`, 28: window edge in pixels, and lines per band.
- `PIX_W`, 8: input pixel and output sample width.
- `THRESH`, 50: contrast threshold on the halved pixel.
- `Clk` in 1: clock.
- `Rst` in 1: reset, synchronous, active-high.
- `pix_in` in PIX_W: unsigned gray pixel.
- `pix_valid` in 1: `pix_in` is valid this cycle.
- `sof` in 1: one-cycle start-of-frame pulse. It may coincide with the first `pix_valid`.
- `eof` in 1: one-cycle end-of-frame pulse.
- `x_out` out PIX_W: signed sample to the classifier.
- `x_valid` out 1: `x_out` is valid.
- `x_ready` in 1: the classifier accepts the sample.
- `win_first` out 1: the current beat is pixel (0,0) of a window.
- `win_last` out 1: the current beat is pixel (WIN-1,WIN-1) of a window.
- `win_col` out clog2(LINE_W/WIN): window index within the band.
- `win_row` out 8: band index within the frame.
- `overflow` out 1: sticky flag, set when a band is dropped. Cleared by `sof` or `Rst`.

## Operation
- **Conversion** (combinational, before write): `h = pix_in >> 1`; the stored sample is `(h > THRESH) ? 2^(PIX_W-1)-1 : h`. The result is always non-negative.
- **Storage**:
  - Two banks, each `WIN*LINE_W` entries of PIX_W bits, with 1-cycle registered read.
  - Write address `wa` runs 0..WIN*LINE_W-1 into bank `wbank`.
- **Write FSM**:
  - `W_IDLE`: waits for `sof`, which clears `wa`, `wbank`, band counter and `overflow`, then goes to `W_FILL`. Pixels are ignored in `W_IDLE`.
  - `W_FILL`: each `pix_valid` writes and increments `wa`. When the write at `wa = WIN*LINE_W-1` completes, the band is full:
    - If the read side is idle, the bank is handed over: `rbank <= wbank`, `wbank` toggles, the band index is latched, and `wa` returns to 0.
    - Otherwise go to `W_DROP`, set `overflow`, and keep `wa` counting without writing.
  - `W_DROP`: discards exactly one band of pixels, then goes back to `W_FILL` on the same bank. The band counter still increments.
  - `eof` in any state goes to `W_IDLE`. A partially filled band is discarded.
  - `sof` in any state restarts as from `W_IDLE`.
- **Read FSM**:
  - `R_IDLE`: on handover, go to `R_RUN` with counters `c`, `r`, `w` = 0.
  - `R_RUN`: read address is `r*LINE_W + w*WIN + c`, with `c` fastest, then `r`, then `w`. Counters advance only when a RAM read is issued into a free pipeline slot.
  - After the address with `w = LINE_W/WIN-1`, `r = c = WIN-1` is issued and its beat is accepted, go to `R_IDLE` and release the bank.
- **Output stage**:
  - 2-entry skid buffer after the RAM so one sample per cycle streams under `x_ready`.
  - `x_out`, `win_*` and the flags stay stable while `x_valid & !x_ready`.
  - `win_col` = `w` and `win_row` = the latched band index, both carried with the data.
- **Arithmetic**: address product widths are sized as clog2(WIN*LINE_W) bits; no truncation is allowed.
- **Rst / `sof` mid-read**:
  - `Rst`: every counter and FSM is cleared; outputs are as listed below.
  - `sof` does not abort the read side. The in-flight band completes.

## Timing
- Reset values: `x_out` = 0, `x_valid` = 0, `win_first` = 0, `win_last` = 0, `win_col` = 0, `win_row` = 0, `overflow` = 0. The FSMs are in `W_IDLE` and `R_IDLE`.
- Handover happens in the cycle after the last band write.
- The first `x_valid` asserts 2 cycles after handover, given `x_ready` = 1.
- With `x_ready` held high, a band replays in exactly `WIN*LINE_W` consecutive beats.
- Back-to-back bands: the read side must release within `WIN*LINE_W` cycles of handover, or the next full band overflows.
- A handover and read release in the same cycle: the release wins first, so the handover succeeds with no overflow.
- `win_first` and `win_last` each last one accepted beat.

## Test plan
- LINE_W=8, WIN=4, ramp pixels 0..255:
  - 32 pixels in -> 32 beats out, windows ordered col0 then col1.
  - Values are `min(p>>1, 127)` with THRESH applied, e.g. p=100 gives 50, p=102 gives 127.
  - `win_first`/`win_last` mark beats 0, 15, 16 and 31.
- Random `x_ready` (50%): the output sequence is identical to the always-ready case, with no beat dropped or duplicated and data held stable while stalled.
- `x_ready` = 0 during the whole second band, third band arrives:
  - `overflow` = 1 and the third band is dropped.
  - The fourth band replays with `win_row` = 3.
- `eof` after 20 of 32 pixels -> no output for the partial band. The next `sof` plus 32 pixels replays normally with `win_row` = 0.
- `Rst` asserted mid-replay -> next cycle all outputs are at reset values. A fresh `sof` band replays correctly.
- `sof` pulses while a band is replaying -> the replay completes intact, and `overflow` clears.
